// File: rtl/snake_pkg.sv
// Shared snake game constants and {x,y} packing helpers used by the map,
// the body FIFO and the game FSM.
package snake_pkg;
  localparam int unsigned XW       = 6;
  localparam int unsigned YW       = 5;
  localparam int unsigned GRID_W   = 40;
  localparam int unsigned GRID_H   = 30;
  localparam int unsigned DEPTH    = GRID_W * GRID_H;
  localparam int unsigned AW       = 11;
  localparam int unsigned GROW     = 3;
  localparam int unsigned PEND_W   = 4;
  localparam int unsigned PEND_MAX = 15;

  typedef logic [XW+YW-1:0] xy_t;

  function automatic xy_t pack_xy(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [XW-1:0] xy_x(input xy_t xy);
    return xy[XW+YW-1:YW];
  endfunction

  function automatic logic [YW-1:0] xy_y(input xy_t xy);
    return xy[YW-1:0];
  endfunction
endpackage

// File: rtl/snake_ring_ram.sv
// Body-cell storage: one synchronous write port, one asynchronous read port,
// sized to map onto distributed RAM.
module snake_ring_ram #(
  parameter int unsigned W     = snake_pkg::XW + snake_pkg::YW,
  parameter int unsigned DEPTH = snake_pkg::DEPTH,
  parameter int unsigned AW    = snake_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/snake_body_fifo.sv
// Ring buffer of snake body cells, oldest first. Pushes the previous head
// every tick and pops the tail unless growth is pending.
module snake_body_fifo #(
  parameter int unsigned XW    = snake_pkg::XW,
  parameter int unsigned YW    = snake_pkg::YW,
  parameter int unsigned DEPTH = snake_pkg::DEPTH,
  parameter int unsigned AW    = snake_pkg::AW,
  parameter int unsigned GROW  = snake_pkg::GROW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic             eat,
  input  logic [XW+YW-1:0] head_xy,
  output logic [XW+YW-1:0] tail_xy,
  output logic             tail_valid,
  output logic             hold,
  output logic [AW-1:0]    length,
  output logic             full,
  output logic             overflow
);
  import snake_pkg::*;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     length_q, length_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              overflow_q, overflow_d;
  logic              pop, push_ok;
  logic [PEND_W+1:0] pend_sum;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign tail_valid = (length_q != '0);
  assign full       = (length_q == AW'(DEPTH));
  assign hold       = eat | (pend_q != '0);
  assign length     = length_q;
  assign overflow   = overflow_q;

  // A full FIFO still accepts the push when the same tick frees a slot.
  assign pop     = tick & ~clear & ~hold & tail_valid;
  assign push_ok = tick & ~clear & ~(full & ~pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    length_d   = length_q;
    pend_d     = pend_q;
    overflow_d = overflow_q;
    pend_sum   = (PEND_W+2)'(pend_q) + (PEND_W+2)'(GROW - 1);
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      length_d   = '0;
      pend_d     = '0;
      overflow_d = 1'b0;
    end else if (tick) begin
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      else         overflow_d = 1'b1;
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_ok, pop})
        2'b10:   length_d = length_q + AW'(1);
        2'b01:   length_d = length_q - AW'(1);
        default: length_d = length_q;
      endcase
      if (eat) begin
        pend_d = (pend_sum > (PEND_W+2)'(PEND_MAX)) ? PEND_W'(PEND_MAX)
                                                     : pend_sum[PEND_W-1:0];
      end else if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      length_q   <= '0;
      pend_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      length_q   <= length_d;
      pend_q     <= pend_d;
      overflow_q <= overflow_d;
    end
  end

  snake_ring_ram #(
    .W     (XW + YW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (head_xy),
    .raddr (rd_ptr_q),
    .rdata (tail_xy)
  );
endmodule

// File: tb/tb_snake_body_fifo.sv
// Directed and random checks of snake_body_fifo against a queue model of
// the snake body, run with a small non-power-of-two depth.
module tb_snake_body_fifo;
  localparam int unsigned XW    = 6;
  localparam int unsigned YW    = 5;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = 4;
  localparam int unsigned GROW  = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic             tick = 1'b0;
  logic             eat = 1'b0;
  logic [XW+YW-1:0] head_xy = '0;
  logic [XW+YW-1:0] tail_xy;
  logic             tail_valid;
  logic             hold;
  logic [AW-1:0]    length;
  logic             full;
  logic             overflow;

  int errors = 0;
  int checks = 0;

  logic [XW+YW-1:0] mq[$];
  int unsigned      m_pend = 0;
  bit               m_ovf = 0;

  always #5 clk = ~clk;

  snake_body_fifo #(
    .XW    (XW),
    .YW    (YW),
    .DEPTH (DEPTH),
    .AW    (AW),
    .GROW  (GROW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .tick       (tick),
    .eat        (eat),
    .head_xy    (head_xy),
    .tail_xy    (tail_xy),
    .tail_valid (tail_valid),
    .hold       (hold),
    .length     (length),
    .full       (full),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XW+YW-1:0] xy(input int unsigned x, input int unsigned y);
    return snake_pkg::pack_xy(XW'(x), YW'(y));
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pend = 0;
    m_ovf  = 0;
  endtask

  // Body model: tail kept while growing, otherwise oldest cell leaves;
  // the head always enters if there is room after that.
  task automatic m_tick(input bit e, input logic [XW+YW-1:0] h);
    bit keep;
    keep = e || (m_pend != 0);
    if (!keep && mq.size() > 0) void'(mq.pop_front());
    if (mq.size() < DEPTH) mq.push_back(h);
    else m_ovf = 1;
    if (e) m_pend = (m_pend + GROW - 1 > 15) ? 15 : m_pend + GROW - 1;
    else if (m_pend != 0) m_pend--;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".length"}, 32'(length), 32'(mq.size()));
    chk({tag, ".tail_valid"}, 32'(tail_valid), 32'(mq.size() > 0));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".hold"}, 32'(hold), 32'(eat || m_pend != 0));
    if (mq.size() > 0) chk({tag, ".tail_xy"}, 32'(tail_xy), 32'(mq[0]));
  endtask

  task automatic step(input string tag, input bit t, input bit e, input bit c,
                      input logic [XW+YW-1:0] h);
    @(negedge clk);
    tick = t; eat = e; clear = c; head_xy = h;
    #1;
    chk({tag, ".hold_pre"}, 32'(hold), 32'(e || m_pend != 0));
    @(posedge clk);
    if (c) m_reset();
    else if (t) m_tick(e, h);
    #1;
    tick = 0; eat = 0; clear = 0;
    #1;
    check_state(tag);
  endtask

  initial begin
    int unsigned len0;
    m_reset();
    // Reset state
    repeat (2) @(negedge clk);
    check_state("reset");
    eat = 1; #1;
    chk("reset.hold_eq_eat", 32'(hold), 32'd1);
    eat = 0;
    reset = 0;

    // First push
    step("first", 1, 0, 0, xy(5, 5));
    chk("first.tail_const", 32'(tail_xy), 32'(xy(5, 5)));
    chk("first.len_const", 32'(length), 32'd1);

    // Walk without growth
    for (int unsigned i = 1; i <= 4; i++) step("walk", 1, 0, 0, xy(i, 1));
    chk("walk.len_const", 32'(length), 32'd1);

    // Idle cycles change nothing
    step("idle", 0, 0, 0, xy(9, 9));
    step("idle", 0, 1, 0, xy(9, 9));

    // One apple keeps the tail for exactly GROW ticks
    len0 = mq.size();
    step("eat0", 1, 1, 0, xy(5, 1));
    step("eat1", 1, 0, 0, xy(6, 1));
    step("eat2", 1, 0, 0, xy(7, 1));
    chk("eat.len_grown", 32'(length), 32'(len0 + GROW));
    chk("eat.hold_done", 32'(hold), 32'd0);
    step("eat3", 1, 0, 0, xy(8, 1));
    chk("eat.len_steady", 32'(length), 32'(len0 + GROW));

    // Back-to-back eats extend the hold
    step("b2b0", 1, 1, 0, xy(9, 1));
    step("b2b1", 1, 1, 0, xy(10, 1));
    for (int unsigned i = 0; i < 5; i++) step("b2b", 1, 0, 0, xy(11 + i, 1));

    // Fill from empty to exactly DEPTH with no pending growth
    step("clr", 1, 0, 1, xy(1, 2));
    for (int unsigned i = 0; i < DEPTH; i++)
      step("fill", 1, (i % GROW) == 0, 0, xy(i, 3));
    chk("fill.full_const", 32'(full), 32'd1);
    // Full with pop: pointers wrap repeatedly, length holds
    for (int unsigned i = 0; i < 2 * DEPTH + 3; i++) step("wrap", 1, 0, 0, xy(i, 4));
    chk("wrap.ovf_const", 32'(overflow), 32'd0);
    chk("wrap.len_const", 32'(length), 32'(DEPTH));
    // Full with hold: push dropped
    step("ovf", 1, 1, 0, xy(20, 20));
    chk("ovf.ovf_const", 32'(overflow), 32'd1);
    chk("ovf.len_const", 32'(length), 32'(DEPTH));
    step("ovf_b", 1, 0, 0, xy(21, 20));

    // clear with tick: nothing written, state zeroed
    step("clrtick", 1, 1, 1, xy(30, 7));
    chk("clrtick.len_const", 32'(length), 32'd0);
    step("postclr", 1, 0, 0, xy(31, 8));
    chk("postclr.tail_const", 32'(tail_xy), 32'(xy(31, 8)));

    // Asynchronous reset in the middle of a hold
    step("prerst", 1, 1, 0, xy(2, 2));
    @(negedge clk); #2;
    reset = 1;
    #1;
    m_reset();
    check_state("asyncrst");
    @(negedge clk);
    reset = 0;
    step("postrst", 1, 0, 0, xy(3, 3));

    // Random play
    for (int unsigned i = 0; i < 400; i++) begin
      bit t, e, c;
      t = ($urandom_range(0, 7) != 0);
      e = ($urandom_range(0, 4) == 0);
      c = ($urandom_range(0, 99) == 0);
      step("rand", t, e, c, (XW+YW)'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
